// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the dual-issue scheduler.
// Holds the load-type sentinel, FSM encodings and scoreboard entry.
package issue_scheduler_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int LD_TYPE_WIDTH = 3;
  localparam int DIV_LAT_DEF   = 8;
  localparam int CNT_W         = 4;

  localparam logic [LD_TYPE_WIDTH-1:0] LD_XXX = '0;

  typedef enum logic {
    SCHED_RUN   = 1'b0,
    SCHED_SPLIT = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                     valid;
    logic [RF_ADDR_WIDTH-1:0] rd;
  } sb_entry_t;

  // x0 is hardwired, so it never carries a dependency.
  function automatic logic src_match(
    input logic [RF_ADDR_WIDTH-1:0] a,
    input logic [RF_ADDR_WIDTH-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-pair to scheduler bundle: flush, two decoded slots, issue/stall.
// master = decode side, slave = scheduler.
interface issue_scheduler_if;
  import issue_scheduler_pkg::*;

  logic                     Flush;
  logic                     Decode_Valid_0;
  logic                     Decode_Valid_1;
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_0;
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_1;
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_0;
  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_1;
  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr_0;
  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr_1;
  logic                     Decode_RdWrtEn_0;
  logic                     Decode_RdWrtEn_1;
  logic [LD_TYPE_WIDTH-1:0] Decode_LdType_0;
  logic [LD_TYPE_WIDTH-1:0] Decode_LdType_1;
  logic                     Decode_MemEn_0;
  logic                     Decode_MemEn_1;
  logic                     Decode_MulDiv_0;
  logic                     Decode_MulDiv_1;
  logic                     Sched_Issue_0;
  logic                     Sched_Issue_1;
  logic                     Sched_StallReq;
  logic                     Sched_Split;
  logic                     Sched_DivBusy;

  modport master (
    output Flush,
    output Decode_Valid_0, Decode_Valid_1,
    output Decode_Rs1Addr_0, Decode_Rs1Addr_1,
    output Decode_Rs2Addr_0, Decode_Rs2Addr_1,
    output Decode_RdAddr_0, Decode_RdAddr_1,
    output Decode_RdWrtEn_0, Decode_RdWrtEn_1,
    output Decode_LdType_0, Decode_LdType_1,
    output Decode_MemEn_0, Decode_MemEn_1,
    output Decode_MulDiv_0, Decode_MulDiv_1,
    input  Sched_Issue_0, Sched_Issue_1,
    input  Sched_StallReq, Sched_Split, Sched_DivBusy
  );

  modport slave (
    input  Flush,
    input  Decode_Valid_0, Decode_Valid_1,
    input  Decode_Rs1Addr_0, Decode_Rs1Addr_1,
    input  Decode_Rs2Addr_0, Decode_Rs2Addr_1,
    input  Decode_RdAddr_0, Decode_RdAddr_1,
    input  Decode_RdWrtEn_0, Decode_RdWrtEn_1,
    input  Decode_LdType_0, Decode_LdType_1,
    input  Decode_MemEn_0, Decode_MemEn_1,
    input  Decode_MulDiv_0, Decode_MulDiv_1,
    output Sched_Issue_0, Sched_Issue_1,
    output Sched_StallReq, Sched_Split, Sched_DivBusy
  );

endinterface

// File: rtl/ld_use_check.sv
// Load-use check for one slot against the two-entry load scoreboard.
// Ports: rs1_i/rs2_i sources, sb0_i/sb1_i entries, hit_o dependency.
module ld_use_check
  import issue_scheduler_pkg::*;
(
  input  logic [RF_ADDR_WIDTH-1:0] rs1_i,
  input  logic [RF_ADDR_WIDTH-1:0] rs2_i,
  input  sb_entry_t                sb0_i,
  input  sb_entry_t                sb1_i,
  output logic                     hit_o
);

  logic h0, h1;

  assign h0 = sb0_i.valid &
              (src_match(rs1_i, sb0_i.rd) |
               src_match(rs2_i, sb0_i.rd));
  assign h1 = sb1_i.valid &
              (src_match(rs1_i, sb1_i.rd) |
               src_match(rs2_i, sb1_i.rd));
  assign hit_o = h0 | h1;

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: load-use, mul/div and intra-pair hazards.
// Ports: clk, rst_n (sync, active-high), sif (slave bundle).
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  issue_scheduler_if.slave   sif
);

  sched_state_e     state_q, state_d;
  sb_entry_t        sb0_q, sb0_d;
  sb_entry_t        sb1_q, sb1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rel_q;

  logic hit0, hit1;
  logic busy, quiet;
  logic div0, div1, raw, pair;
  logic haz0, haz1_ld, haz1;
  logic iss0, iss1, stall;
  logic md_iss;

  ld_use_check u_chk0 (
    .rs1_i (sif.Decode_Rs1Addr_0),
    .rs2_i (sif.Decode_Rs2Addr_0),
    .sb0_i (sb0_q),
    .sb1_i (sb1_q),
    .hit_o (hit0)
  );

  ld_use_check u_chk1 (
    .rs1_i (sif.Decode_Rs1Addr_1),
    .rs2_i (sif.Decode_Rs2Addr_1),
    .sb0_i (sb0_q),
    .sb1_i (sb1_q),
    .hit_o (hit1)
  );

  // Outputs stay silent during reset and the first cycle after it.
  assign quiet = rst_n | rel_q;
  assign busy  = (cnt_q != '0);

  always_comb begin
    div0 = sif.Decode_MulDiv_0 & busy;
    div1 = sif.Decode_MulDiv_1 & busy;
    raw  = sif.Decode_RdWrtEn_0 &
           (src_match(sif.Decode_Rs1Addr_1, sif.Decode_RdAddr_0) |
            src_match(sif.Decode_Rs2Addr_1, sif.Decode_RdAddr_0));
    // An empty slot 0 cannot conflict with slot 1.
    pair = sif.Decode_Valid_0 &
           (raw |
            (sif.Decode_MemEn_0 & sif.Decode_MemEn_1) |
            (sif.Decode_MulDiv_0 & sif.Decode_MulDiv_1));
    haz0    = hit0 | div0;
    haz1_ld = hit1 | div1;
    haz1    = haz1_ld | pair;

    iss0    = 1'b0;
    iss1    = 1'b0;
    stall   = 1'b0;
    state_d = state_q;

    if (sif.Flush) begin
      state_d = SCHED_RUN;
    end else if (!quiet) begin
      unique case (state_q)
        SCHED_RUN: begin
          if (sif.Decode_Valid_0 & haz0) begin
            stall = 1'b1;
          end else if (sif.Decode_Valid_1 & haz1) begin
            iss0    = sif.Decode_Valid_0;
            stall   = 1'b1;
            state_d = SCHED_SPLIT;
          end else begin
            iss0 = sif.Decode_Valid_0;
            iss1 = sif.Decode_Valid_1;
          end
        end
        SCHED_SPLIT: begin
          // Slot 0 already left; only slot 1 vs older ops matters.
          if (sif.Decode_Valid_1 & haz1_ld) begin
            stall = 1'b1;
          end else begin
            iss1    = sif.Decode_Valid_1;
            state_d = SCHED_RUN;
          end
        end
        default: state_d = SCHED_RUN;
      endcase
    end

    sb0_d.valid = iss0 & sif.Decode_RdWrtEn_0 &
                  (sif.Decode_LdType_0 != LD_XXX);
    sb0_d.rd    = sif.Decode_RdAddr_0;
    sb1_d.valid = iss1 & sif.Decode_RdWrtEn_1 &
                  (sif.Decode_LdType_1 != LD_XXX);
    sb1_d.rd    = sif.Decode_RdAddr_1;

    md_iss = (iss0 & sif.Decode_MulDiv_0) |
             (iss1 & sif.Decode_MulDiv_1);
    if (md_iss)
      cnt_d = CNT_W'(DIV_LAT - 1);
    else if (busy)
      cnt_d = cnt_q - 1'b1;
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= SCHED_RUN;
      sb0_q   <= '0;
      sb1_q   <= '0;
      cnt_q   <= '0;
      rel_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sb0_q   <= sb0_d;
      sb1_q   <= sb1_d;
      cnt_q   <= cnt_d;
      rel_q   <= 1'b0;
    end
  end

  assign sif.Sched_Issue_0  = iss0;
  assign sif.Sched_Issue_1  = iss1;
  assign sif.Sched_StallReq = stall;
  assign sif.Sched_Split    = ~rst_n & (state_q == SCHED_SPLIT);
  assign sif.Sched_DivBusy  = ~rst_n & busy;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler.
// Outputs packed as {Issue_0, Issue_1, StallReq, Split, DivBusy}.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  issue_scheduler_if bus();

  issue_scheduler #(.DIV_LAT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus)
  );

  logic [4:0] outs;
  assign outs = {bus.Sched_Issue_0, bus.Sched_Issue_1,
                 bus.Sched_StallReq, bus.Sched_Split,
                 bus.Sched_DivBusy};

  localparam logic [2:0] LW = 3'd2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic s0(input logic v, input logic [4:0] rs1,
                    input logic [4:0] rs2, input logic [4:0] rd,
                    input logic we, input logic [2:0] ld,
                    input logic mem, input logic md);
    bus.Decode_Valid_0   = v;
    bus.Decode_Rs1Addr_0 = rs1;
    bus.Decode_Rs2Addr_0 = rs2;
    bus.Decode_RdAddr_0  = rd;
    bus.Decode_RdWrtEn_0 = we;
    bus.Decode_LdType_0  = ld;
    bus.Decode_MemEn_0   = mem;
    bus.Decode_MulDiv_0  = md;
  endtask

  task automatic s1(input logic v, input logic [4:0] rs1,
                    input logic [4:0] rs2, input logic [4:0] rd,
                    input logic we, input logic [2:0] ld,
                    input logic mem, input logic md);
    bus.Decode_Valid_1   = v;
    bus.Decode_Rs1Addr_1 = rs1;
    bus.Decode_Rs2Addr_1 = rs2;
    bus.Decode_RdAddr_1  = rd;
    bus.Decode_RdWrtEn_1 = we;
    bus.Decode_LdType_1  = ld;
    bus.Decode_MemEn_1   = mem;
    bus.Decode_MulDiv_1  = md;
  endtask

  task automatic idle();
    bus.Flush = 1'b0;
    s0(0, 0, 0, 0, 0, LD_XXX, 0, 0);
    s1(0, 0, 0, 0, 0, LD_XXX, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    s0(1, 2, 3, 1, 1, LD_XXX, 0, 0);
    s1(1, 5, 6, 4, 1, LD_XXX, 0, 0);
    nxt();
    nxt();
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      $display("FAIL reset_hold got=%b exp=%b", outs, 5'b00000);
      fails++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      $display("FAIL reset_release got=%b exp=%b", outs, 5'b00000);
      fails++;
    end
    nxt();
    #1;
    checks++;
    if (outs !== 5'b11000) begin
      $display("FAIL reset_first_issue got=%b exp=%b", outs, 5'b11000);
      fails++;
    end
    nxt();
    idle();
  endtask

  task automatic test_load_split();
    nxt();
    s0(1, 2, 0, 5, 1, LW, 1, 0);
    s1(1, 5, 1, 6, 1, LD_XXX, 0, 0);
    #1;
    checks++;
    if (outs !== 5'b10100) begin
      $display("FAIL ldsplit_c0 got=%b exp=%b", outs, 5'b10100);
      fails++;
    end
    nxt();
    #1;
    checks++;
    if (outs !== 5'b00110) begin
      $display("FAIL ldsplit_c1 got=%b exp=%b", outs, 5'b00110);
      fails++;
    end
    nxt();
    #1;
    checks++;
    if (outs !== 5'b01010) begin
      $display("FAIL ldsplit_c2 got=%b exp=%b", outs, 5'b01010);
      fails++;
    end
    nxt();
    idle();
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      $display("FAIL ldsplit_run got=%b exp=%b", outs, 5'b00000);
      fails++;
    end
  endtask

  task automatic test_load_use();
    nxt();
    s0(1, 2, 0, 7, 1, LW, 1, 0);
    #1;
    checks++;
    if (outs !== 5'b10000) begin
      $display("FAIL lduse_lw got=%b exp=%b", outs, 5'b10000);
      fails++;
    end
    nxt();
    s0(1, 7, 0, 8, 1, LD_XXX, 0, 0);
    s1(1, 0, 0, 0, 1, LD_XXX, 0, 0);
    #1;
    checks++;
    if (outs !== 5'b00100) begin
      $display("FAIL lduse_stall got=%b exp=%b", outs, 5'b00100);
      fails++;
    end
    nxt();
    #1;
    checks++;
    if (outs !== 5'b11000) begin
      $display("FAIL lduse_go got=%b exp=%b", outs, 5'b11000);
      fails++;
    end
    nxt();
    idle();
    s0(1, 2, 0, 0, 1, LW, 1, 0);
    #1;
    checks++;
    if (outs !== 5'b10000) begin
      $display("FAIL x0_load got=%b exp=%b", outs, 5'b10000);
      fails++;
    end
    nxt();
    s0(1, 0, 0, 9, 1, LD_XXX, 0, 0);
    #1;
    checks++;
    if (outs !== 5'b10000) begin
      $display("FAIL x0_no_hazard got=%b exp=%b", outs, 5'b10000);
      fails++;
    end
    nxt();
    idle();
  endtask

  task automatic test_mem_pair();
    nxt();
    s0(1, 2, 0, 1, 1, LW, 1, 0);
    s1(1, 4, 3, 0, 0, LD_XXX, 1, 0);
    #1;
    checks++;
    if (outs !== 5'b10100) begin
      $display("FAIL mempair_c0 got=%b exp=%b", outs, 5'b10100);
      fails++;
    end
    nxt();
    #1;
    checks++;
    if (outs !== 5'b01010) begin
      $display("FAIL mempair_c1 got=%b exp=%b", outs, 5'b01010);
      fails++;
    end
    nxt();
    idle();
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      $display("FAIL mempair_run got=%b exp=%b", outs, 5'b00000);
      fails++;
    end
  endtask

  task automatic test_div();
    nxt();
    s0(1, 10, 11, 9, 1, LD_XXX, 0, 1);
    #1;
    checks++;
    if (outs !== 5'b10000) begin
      $display("FAIL div_issue got=%b exp=%b", outs, 5'b10000);
      fails++;
    end
    nxt();
    s0(1, 13, 14, 12, 1, LD_XXX, 0, 1);
    s1(1, 16, 17, 15, 1, LD_XXX, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      #1;
      checks++;
      if (outs !== 5'b00101) begin
        $display("FAIL div_stall_%0d got=%b exp=%b", k, outs, 5'b00101);
        fails++;
      end
      nxt();
    end
    #1;
    checks++;
    if (outs !== 5'b11000) begin
      $display("FAIL div_mul_go got=%b exp=%b", outs, 5'b11000);
      fails++;
    end
    nxt();
    idle();
    #1;
    checks++;
    if (outs !== 5'b00001) begin
      $display("FAIL div_rebusy got=%b exp=%b", outs, 5'b00001);
      fails++;
    end
    repeat (6) nxt();
    #1;
    checks++;
    if (outs !== 5'b00001) begin
      $display("FAIL div_last_busy got=%b exp=%b", outs, 5'b00001);
      fails++;
    end
    nxt();
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      $display("FAIL div_free got=%b exp=%b", outs, 5'b00000);
      fails++;
    end
  endtask

  task automatic test_invalid_slot0();
    nxt();
    s0(0, 3, 3, 3, 1, LW, 1, 1);
    s1(1, 3, 4, 5, 1, LD_XXX, 1, 1);
    #1;
    checks++;
    if (outs !== 5'b01000) begin
      $display("FAIL inv0_pass got=%b exp=%b", outs, 5'b01000);
      fails++;
    end
    nxt();
    idle();
    repeat (8) nxt();
  endtask

  task automatic test_flush();
    nxt();
    s0(1, 2, 0, 5, 1, LW, 1, 0);
    s1(1, 5, 1, 6, 1, LD_XXX, 0, 0);
    #1;
    checks++;
    if (outs !== 5'b10100) begin
      $display("FAIL flush_split got=%b exp=%b", outs, 5'b10100);
      fails++;
    end
    nxt();
    bus.Flush = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00010) begin
      $display("FAIL flush_wins got=%b exp=%b", outs, 5'b00010);
      fails++;
    end
    nxt();
    idle();
    s0(1, 5, 5, 20, 1, LD_XXX, 0, 0);
    #1;
    checks++;
    if (outs !== 5'b10000) begin
      $display("FAIL flush_sb_clear got=%b exp=%b", outs, 5'b10000);
      fails++;
    end
    nxt();
    idle();
  endtask

  task automatic test_reset_mid();
    nxt();
    s0(1, 10, 11, 9, 1, LD_XXX, 0, 1);
    #1;
    checks++;
    if (outs !== 5'b10000) begin
      $display("FAIL rmid_div got=%b exp=%b", outs, 5'b10000);
      fails++;
    end
    nxt();
    s0(1, 2, 0, 1, 1, LW, 1, 0);
    s1(1, 4, 3, 0, 0, LD_XXX, 1, 0);
    #1;
    checks++;
    if (outs !== 5'b10101) begin
      $display("FAIL rmid_split got=%b exp=%b", outs, 5'b10101);
      fails++;
    end
    nxt();
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      $display("FAIL rmid_in_reset got=%b exp=%b", outs, 5'b00000);
      fails++;
    end
    nxt();
    rst_n = 1'b0;
    s0(1, 13, 14, 12, 1, LD_XXX, 0, 1);
    s1(1, 16, 17, 15, 1, LD_XXX, 0, 0);
    #1;
    checks++;
    if (outs !== 5'b00000) begin
      $display("FAIL rmid_release got=%b exp=%b", outs, 5'b00000);
      fails++;
    end
    nxt();
    #1;
    checks++;
    if (outs !== 5'b11000) begin
      $display("FAIL rmid_mul_go got=%b exp=%b", outs, 5'b11000);
      fails++;
    end
    nxt();
    idle();
    #1;
    checks++;
    if (outs !== 5'b00001) begin
      $display("FAIL rmid_busy got=%b exp=%b", outs, 5'b00001);
      fails++;
    end
    repeat (8) nxt();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_load_split();
    test_load_use();
    test_mem_pair();
    test_div();
    test_invalid_slot0();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter DIV_LAT, default 8, cycles the shared mul/div unit stays busy after accepting an op (legal 2..15).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  synchronous reset, asserted = 1.
REQ-005 Flush  input  1  squash the decode pair this cycle.
REQ-006 Decode_Valid_0/1  input  1 each  slot holds a real instruction.
REQ-007 Decode_Rs1Addr_0/1, Decode_Rs2Addr_0/1  input  RF_ADDR_WIDTH each  source registers.
REQ-008 Decode_RdAddr_0/1  input  RF_ADDR_WIDTH each  destination register.
REQ-009 Decode_RdWrtEn_0/1  input  1 each  slot writes rd.
REQ-010 Decode_LdType_0/1  input  LD_TYPE_WIDTH each  LD_XXX = not a load.
REQ-011 Decode_MemEn_0/1  input  1 each  load or store.
REQ-012 Decode_MulDiv_0/1  input  1 each  needs the shared mul/div unit.
REQ-013 Sched_Issue_0/1  output  1 each  slot enters EX this cycle.
REQ-014 Sched_StallReq  output  1  hold IF and the ID pair.
REQ-015 Sched_Split  output  1  FSM is in SPLIT (slot 0 already issued).
REQ-016 Sched_DivBusy  output  1  mul/div counter non-zero.

Function
REQ-017 Register addr 0 never creates a hazard; a source "matches" only when non-zero and equal.
REQ-018 Scoreboard: two entries {valid, rd} recording loads (LdType != LD_XXX, RdWrtEn = 1) issued last cycle per slot; rewritten every cycle, entry invalid if its slot did not issue a load.
REQ-019 Load-use hazard on a slot: either source matches a valid scoreboard entry.
REQ-020 Div hazard on a slot: MulDiv = 1 and DivBusy = 1.
REQ-021 Pair hazard on slot 1 (RUN only): slot 1 source matches slot 0 rd with RdWrtEn_0; or MemEn_0 & MemEn_1; or MulDiv_0 & MulDiv_1.
REQ-022 FSM states RUN, SPLIT; outputs Issue/StallReq are combinational from state, inputs and registers (zero-latency).
REQ-023 RUN, slot 0 valid with hazard: Issue_0 = Issue_1 = 0, StallReq = 1, stay RUN.
REQ-024 RUN, slot 0 clear, slot 1 valid with any hazard: Issue_0 = 1, Issue_1 = 0, StallReq = 1, next SPLIT.
REQ-025 RUN, no hazard: each valid slot issues, StallReq = 0; invalid slots never issue, and an invalid slot 0 does not block slot 1.
REQ-026 SPLIT: slot 0 ignored; slot 1 checked only for load-use and div hazards; hazard -> StallReq = 1, stay SPLIT; clear -> Issue_1 = 1, StallReq = 0, next RUN.
REQ-027 Div counter loads DIV_LAT-1 on any cycle a MulDiv op issues; else decrements while non-zero; DivBusy = (counter != 0).
REQ-028 Flush: both Issue = 0, StallReq = 0, next state RUN, scoreboard cleared next cycle; div counter unaffected.
REQ-029 Flush coincident with a hazard: flush wins.

Reset
REQ-030 While rst_n = 1: state RUN, scoreboard invalid, counter 0; Issue_0/1, StallReq, Split, DivBusy all 0 in that cycle and the first cycle after release.
REQ-031 Reset mid-SPLIT or mid-divide abandons it; no issue is generated for the held slot.

Structure
REQ-032 Define.v holds LD_XXX, SCHED_RUN/SCHED_SPLIT encodings and DIV_LAT default.
REQ-033 One sub-module, ld_use_check: compares two sources against the two scoreboard entries, returns hit; instanced once per slot.

Verification
REQ-034 Pair {lw x5; add x6,x5,x1} -> cycle 0 Issue_0 = 1, Split; cycle 1 stall (x5 in scoreboard); cycle 2 Issue_1 = 1, RUN.
REQ-035 lw x7 issued, next pair {add x8,x7,x0; nop} -> one stall cycle with no issue, then both issue.
REQ-036 Pair {lw; sw} -> split, slot 1 issues next cycle, no stall beyond 1 cycle.
REQ-037 div issued, DIV_LAT = 8, then pair {mul; add} -> 7 stall cycles, mul issues on cycle 8 with add.
REQ-038 Flush asserted while in SPLIT with hazard -> no issue, StallReq = 0, next cycle RUN with empty scoreboard.
REQ-039 rst_n asserted while DivBusy = 1 and in SPLIT -> all outputs 0 next cycle, a following MulDiv pair issues immediately.
